ex_muldiv_hilo: RTL and testbench

//  EX-stage arithmetic unit for the HI/LO register pair, sitting beside the logic/shift/move datapath.

---
 rtl/ex_pkg.sv | 53 +++++
 rtl/div_unit.sv | 127 ++++++++++++
 rtl/ex_muldiv_hilo.sv | 125 ++++++++++++
 tb/tb_ex_muldiv_hilo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: ALU operation codes, write-enable levels and the
// divider state encoding used by the HI/LO arithmetic unit.
package ex_pkg;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BYZERO,
    DIV_ON,
    DIV_END
  } div_state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_MUL,
    OP_MACC,
    OP_DIV
  } op_class_t;

  function automatic op_class_t op_class(input logic [7:0] op);
    op_class_t cls;
    case (op)
      EXE_MULT_OP, EXE_MULTU_OP:                           cls = OP_MUL;
      EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: cls = OP_MACC;
      EXE_DIV_OP, EXE_DIVU_OP:                             cls = OP_DIV;
      default:                                             cls = OP_NONE;
    endcase
    return cls;
  endfunction

  function automatic logic op_is_signed(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MADD_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_DIV_OP);
  endfunction

  function automatic logic op_is_sub(input logic [7:0] op);
    return (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes, with
// the sign correction applied combinationally when the result is presented.
module div_unit
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsor_q, dsor_d;
  logic             neg_quot_q, neg_quot_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    dsor_d     = dsor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    busy_o     = 1'b0;
    ready_o    = 1'b0;
    quot_o     = '0;
    rem_o      = '0;
    trial      = {rem_q, quot_q[WIDTH-1]};
    diff       = trial - {1'b0, dsor_q};

    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          busy_o = 1'b1;
          cnt_d  = '0;
          if (divisor_i == '0) begin
            // Result is final already; clearing the sign flags keeps END from touching it.
            state_d    = DIV_BYZERO;
            quot_d     = '1;
            rem_d      = dividend_i;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
          end else begin
            state_d    = DIV_ON;
            quot_d     = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
            dsor_d     = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
            rem_d      = '0;
            neg_quot_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
            neg_rem_d  = signed_i & dividend_i[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        busy_o  = 1'b1;
        state_d = DIV_END;
      end
      DIV_ON: begin
        busy_o = 1'b1;
        // quot_q doubles as the dividend shift register; quotient bits enter at the bottom.
        if (!diff[WIDTH]) begin
          rem_d  = diff[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d  = trial[WIDTH-1:0];
          quot_d = {quot_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DIV_END;
      end
      DIV_END: begin
        ready_o = 1'b1;
        quot_o  = neg_quot_q ? -quot_q : quot_q;
        rem_o   = neg_rem_q  ? -rem_q  : rem_q;
        cnt_d   = '0;
        state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (annul_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
      busy_o  = 1'b0;
      ready_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dsor_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dsor_q     <= dsor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_hilo.sv
// EX-stage HI/LO arithmetic: forwarding, single-cycle multiply, two-cycle
// multiply-accumulate and an iterative divider, with stall request and HI/LO write.
module ex_muldiv_hilo
  import ex_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MADD_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       aluop_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic             mem_whilo_i,
  input  logic [WIDTH-1:0] mem_hi_i,
  input  logic [WIDTH-1:0] mem_lo_i,
  input  logic             wb_whilo_i,
  input  logic [WIDTH-1:0] wb_hi_i,
  input  logic [WIDTH-1:0] wb_lo_i,
  input  logic             flush_i,
  output logic             stallreq_o,
  output logic             whilo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  op_class_t          op_cls;
  logic               is_macc;
  logic               is_signed;
  logic [2*WIDTH-1:0] hilo_fwd;
  logic [2*WIDTH-1:0] mul_a, mul_b, product;
  logic [2*WIDTH-1:0] macc_sum;
  logic [2*WIDTH-1:0] temp_q, temp_d;
  logic               cnt_q, cnt_d;

  logic               div_busy, div_ready;
  logic [WIDTH-1:0]   div_quot, div_rem;

  assign op_cls    = op_class(aluop_i);
  assign is_macc   = (MADD_EN != 0) && (op_cls == OP_MACC);
  assign is_signed = op_is_signed(aluop_i);

  always_comb begin
    hilo_fwd = {hi_i, lo_i};
    if (mem_whilo_i)     hilo_fwd = {mem_hi_i, mem_lo_i};
    else if (wb_whilo_i) hilo_fwd = {wb_hi_i, wb_lo_i};
  end

  // Sign/zero extend to full width; the low 2*WIDTH bits of the product are exact either way.
  always_comb begin
    mul_a   = {{WIDTH{is_signed & reg1_i[WIDTH-1]}}, reg1_i};
    mul_b   = {{WIDTH{is_signed & reg2_i[WIDTH-1]}}, reg2_i};
    product = mul_a * mul_b;
  end

  assign macc_sum = op_is_sub(aluop_i) ? (hilo_fwd - temp_q) : (hilo_fwd + temp_q);

  div_unit #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    ((op_cls == OP_DIV) && !flush_i),
    .signed_i   (is_signed),
    .annul_i    (flush_i),
    .dividend_i (reg1_i),
    .divisor_i  (reg2_i),
    .busy_o     (div_busy),
    .ready_o    (div_ready),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  always_comb begin
    stallreq_o = 1'b0;
    whilo_o    = WriteDisable;
    hi_o       = WIDTH'(ZeroWord);
    lo_o       = WIDTH'(ZeroWord);
    cnt_d      = 1'b0;
    temp_d     = temp_q;

    if (is_macc) begin
      if (!cnt_q) begin
        temp_d     = product;
        cnt_d      = 1'b1;
        stallreq_o = 1'b1;
      end else begin
        whilo_o      = WriteEnable;
        {hi_o, lo_o} = macc_sum;
      end
    end else if (op_cls == OP_MUL) begin
      whilo_o      = WriteEnable;
      {hi_o, lo_o} = product;
    end

    if (div_ready) begin
      whilo_o = WriteEnable;
      hi_o    = div_rem;
      lo_o    = div_quot;
    end
    if (div_busy) stallreq_o = 1'b1;

    // Annulled or reset cycles must neither stall nor write anything.
    if (flush_i || rst) begin
      stallreq_o = 1'b0;
      whilo_o    = WriteDisable;
      hi_o       = WIDTH'(ZeroWord);
      lo_o       = WIDTH'(ZeroWord);
      cnt_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 1'b0;
      temp_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      temp_q <= temp_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Directed bench for ex_muldiv_hilo: expected HI/LO writes and preceding stall
// lengths are queued at issue and compared by an independent monitor.
module tb_ex_muldiv_hilo;

  localparam logic [7:0] NOP   = 8'h00;
  localparam logic [7:0] OR_OP = 8'h25;
  localparam logic [7:0] MULT  = 8'h18;
  localparam logic [7:0] MULTU = 8'h19;
  localparam logic [7:0] DIV   = 8'h1A;
  localparam logic [7:0] DIVU  = 8'h1B;
  localparam logic [7:0] MADD  = 8'hA6;
  localparam logic [7:0] MADDU = 8'hA8;
  localparam logic [7:0] MSUB  = 8'hAA;
  localparam logic [7:0] MSUBU = 8'hAB;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  stall;
  } exp_t;

  logic        clk, rst, flush;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2, hi_in, lo_in, mem_hi, mem_lo, wb_hi, wb_lo;
  logic        mem_whilo, wb_whilo;
  logic        stallreq, whilo;
  logic [31:0] hi_out, lo_out;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   wr_idx   = 0;
  int   stall_run = 0;

  ex_muldiv_hilo #(.WIDTH(32), .MADD_EN(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .aluop_i     (aluop),
    .reg1_i      (reg1),
    .reg2_i      (reg2),
    .hi_i        (hi_in),
    .lo_i        (lo_in),
    .mem_whilo_i (mem_whilo),
    .mem_hi_i    (mem_hi),
    .mem_lo_i    (mem_lo),
    .wb_whilo_i  (wb_whilo),
    .wb_hi_i     (wb_hi),
    .wb_lo_i     (wb_lo),
    .flush_i     (flush),
    .stallreq_o  (stallreq),
    .whilo_o     (whilo),
    .hi_o        (hi_out),
    .lo_o        (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every HI/LO write is matched against the oldest expectation.
  always @(negedge clk) begin
    if (whilo === 1'b1) begin
      if (exp_q.size() == 0) begin
        check($sformatf("spurious_write%0d", wr_idx), {63'd0, whilo}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("wr%0d_hi", wr_idx), {32'd0, hi_out}, {32'd0, e.hi});
        check($sformatf("wr%0d_lo", wr_idx), {32'd0, lo_out}, {32'd0, e.lo});
        check($sformatf("wr%0d_stall_cycles", wr_idx), 64'(stall_run), {56'd0, e.stall});
      end
      wr_idx++;
      stall_run = 0;
    end else if (stallreq === 1'b1) begin
      stall_run++;
    end else begin
      stall_run = 0;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    aluop = op;
    reg1  = a;
    reg2  = b;
  endtask

  task automatic set_fwd(input logic mw, input logic [31:0] mh, input logic [31:0] ml,
                         input logic ww, input logic [31:0] wh, input logic [31:0] wl,
                         input logic [31:0] ah, input logic [31:0] al);
    mem_whilo = mw; mem_hi = mh; mem_lo = ml;
    wb_whilo  = ww; wb_hi  = wh; wb_lo  = wl;
    hi_in     = ah; lo_in  = al;
  endtask

  // Issue an op, hold it for the given number of cycles, then return to NOP.
  task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input logic [7:0] estall, input int cycles);
    exp_t e;
    e.hi = ehi; e.lo = elo; e.stall = estall;
    exp_q.push_back(e);
    set_op(op, a, b);
    repeat (cycles) next_cycle();
    set_op(NOP, 32'd0, 32'd0);
    next_cycle();
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    flush = 1'b0;
    set_fwd(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    set_op(MULT, 32'd4, 32'd5);

    // Outputs are held at zero while reset is asserted, even with an op present.
    @(negedge clk);
    check("rst_whilo", {63'd0, whilo}, 64'd0);
    check("rst_stall", {63'd0, stallreq}, 64'd0);
    check("rst_lo", {32'd0, lo_out}, 64'd0);
    next_cycle();
    rst = 1'b0;
    set_op(NOP, 32'd0, 32'd0);
    next_cycle();

    // Non-arithmetic op with the divider idle produces nothing.
    set_op(OR_OP, 32'h1234_5678, 32'h0000_00FF);
    @(negedge clk);
    check("nop_whilo", {63'd0, whilo}, 64'd0);
    check("nop_stall", {63'd0, stallreq}, 64'd0);
    check("nop_hilo", {hi_out, lo_out}, 64'd0);
    next_cycle();
    set_op(NOP, 32'd0, 32'd0);

    // Multiplies: -2*3 signed, (2^32-2)*3 unsigned.
    run_op(MULT,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 8'd0, 1);
    run_op(MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 8'd0, 1);

    // MADD: MEM forwarding wins over WB and architectural HI/LO: 5 + 6 = 11.
    set_fwd(1'b1, 32'd0, 32'd5, 1'b1, 32'd0, 32'd100, 32'd0, 32'd1000);
    run_op(MADD, 32'd2, 32'd3, 32'd0, 32'd11, 8'd1, 2);
    // MSUB: WB forwarding wins over architectural: 5 - 6 = -1.
    set_fwd(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 32'd5, 32'd0, 32'd1000);
    run_op(MSUB, 32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd1, 2);
    // MADDU wrapping to zero: 0xFFFFFFFE_00000001 + 0x00000001_FFFFFFFF.
    set_fwd(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF);
    run_op(MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 8'd1, 2);
    // MSUBU borrowing across the HI/LO boundary: 0x1_00000000 - 1.
    set_fwd(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd1, 32'd0);
    run_op(MSUBU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 8'd1, 2);
    set_fwd(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

    // Divides: stall for 33 cycles, result on cycle 33 (zero divisor: 2 and 2).
    run_op(DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 8'd33, 34);
    run_op(DIVU, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 8'd2,  3);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 8'd33, 34);
    run_op(DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 8'd33, 34);

    // Reset in the middle of a divide abandons it without a write.
    set_op(DIV, 32'd50, 32'd5);
    repeat (5) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_div_stall", {63'd0, stallreq}, 64'd0);
    next_cycle();
    rst = 1'b0;
    set_op(NOP, 32'd0, 32'd0);
    repeat (40) next_cycle();

    // Flush at ON cnt=10: no stall or write in that cycle, idle afterwards.
    set_op(DIVU, 32'd1000, 32'd3);
    repeat (11) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check("flush_stall", {63'd0, stallreq}, 64'd0);
    check("flush_whilo", {63'd0, whilo}, 64'd0);
    next_cycle();
    flush = 1'b0;
    set_op(NOP, 32'd0, 32'd0);
    @(negedge clk);
    check("post_flush_stall", {63'd0, stallreq}, 64'd0);
    next_cycle();
    run_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 8'd33, 34);

    // Reset during MADD cycle 0, then a clean MULT and MADD.
    set_op(MADD, 32'd2, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_madd_stall", {63'd0, stallreq}, 64'd0);
    next_cycle();
    rst = 1'b0;
    set_op(NOP, 32'd0, 32'd0);
    @(negedge clk);
    check("post_rst_stall", {63'd0, stallreq}, 64'd0);
    check("post_rst_whilo", {63'd0, whilo}, 64'd0);
    next_cycle();
    run_op(MULT, 32'd4, 32'd5, 32'd0, 32'd20, 8'd0, 1);
    run_op(MADD, 32'd1, 32'd1, 32'd0, 32'd1,  8'd1, 2);

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      next_cycle();
      guard++;
    end
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    repeat (3) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
